// File: rtl/deff_ddr_pkg.sv
// ---------------------------------------------------------------------------
// deff_ddr_pkg
//   Shared constants and helpers for the D-PHY DDR output flip-flop.
//   The two state registers hold an XOR-encoded form of the serial stream.
//   XOR-ing them together recovers the bit most recently launched.
//   No ports; imported by the interface users and the top module.
// ---------------------------------------------------------------------------
package deff_ddr_pkg;

  // Value both edge registers take on reset (gives Dp=0, Dn=1).
  localparam logic Q_RST = 1'b0;

  // Encode a new bit against the opposite-edge register.
  // Once the register is updated, q1 ^ q2 equals the new bit.
  function automatic logic ddr_encode(input logic bit_in, input logic other_q);
    return bit_in ^ other_q;
  endfunction

  // Recover the launched serial bit from the two edge registers.
  function automatic logic ddr_decode(input logic q1, input logic q2);
    return q1 ^ q2;
  endfunction

endpackage : deff_ddr_pkg

// File: rtl/deff_ddr_if.sv
// ---------------------------------------------------------------------------
// deff_ddr_if
//   Bundle of the data/control signals of the DDR output flip-flop.
//   Signals:
//     Enable     1 = capture new bits, 0 = hold current output
//     Serial_B1  bit launched at the rising edge
//     Serial_B2  bit launched at the falling edge
//     Dp         differential positive output (serial bit)
//     Dn         differential negative output, always ~Dp
//   Modports:
//     master  drives Enable/Serial_B1/Serial_B2 and observes Dp/Dn
//     slave   the flip-flop itself
// ---------------------------------------------------------------------------
interface deff_ddr_if;
  logic Enable;
  logic Serial_B1;
  logic Serial_B2;
  logic Dp;
  logic Dn;

  modport master (
    output Enable,
    output Serial_B1,
    output Serial_B2,
    input  Dp,
    input  Dn
  );

  modport slave (
    input  Enable,
    input  Serial_B1,
    input  Serial_B2,
    output Dp,
    output Dn
  );
endinterface : deff_ddr_if

// File: rtl/deff_ddr.sv
// ---------------------------------------------------------------------------
// deff_ddr
//   Double-edge output flip-flop of the D-PHY transmit driver.
//   Serial_B1 is launched on the rising edge of TX_DDR_clk.
//   Serial_B2 is launched on the falling edge of TX_DDR_clk.
//   The result is driven as the differential pair Dp/Dn.
//   Glitch-free operation: two single-edge registers hold an XOR-encoded
//   stream, and the output is their XOR. The clock never enters the data path.
//   Ports:
//     TX_DDR_clk  in  DDR bit clock, both edges active
//     TX_rst      in  synchronous active-low reset, sampled on each flop's edge
//     bus         deff_ddr_if.slave (Enable, Serial_B1, Serial_B2, Dp, Dn)
// ---------------------------------------------------------------------------
module deff_ddr
  import deff_ddr_pkg::*;
(
  input  logic      TX_DDR_clk,
  input  logic      TX_rst,
  deff_ddr_if.slave bus
);

  logic q1_r;  // rising-edge register
  logic q2_r;  // falling-edge register
  logic dp_s;

  // Rising-edge register: reset beats Enable; when disabled it holds.
  always_ff @(posedge TX_DDR_clk) begin
    if (!TX_rst) begin
      q1_r <= Q_RST;
    end else if (bus.Enable) begin
      q1_r <= ddr_encode(bus.Serial_B1, q2_r);
    end else begin
      q1_r <= q1_r;
    end
  end

  // Falling-edge register: reset beats Enable; when disabled it holds.
  always_ff @(negedge TX_DDR_clk) begin
    if (!TX_rst) begin
      q2_r <= Q_RST;
    end else if (bus.Enable) begin
      q2_r <= ddr_encode(bus.Serial_B2, q1_r);
    end else begin
      q2_r <= q2_r;
    end
  end

  // The output is combinational by design. A further register would need
  // a clock running at twice the bit rate.
  assign dp_s   = ddr_decode(q1_r, q2_r);
  assign bus.Dp = dp_s;
  assign bus.Dn = ~dp_s;

endmodule : deff_ddr

// File: tb/tb_deff_ddr.sv
// ---------------------------------------------------------------------------
// tb_deff_ddr
//   Self-checking bench for deff_ddr.
//   The stimulus process drives one half-period at a time.
//   For each edge it pushes the hand-computed Dp expected after that edge.
//   A monitor pops one entry 1 time unit after every clock edge.
//   It compares Dp and Dn against that entry.
// ---------------------------------------------------------------------------
module tb_deff_ddr;

  typedef struct {
    logic  chk;
    logic  dp;
    string name;
  } exp_t;

  logic TX_DDR_clk;
  logic TX_rst;

  deff_ddr_if bus ();

  deff_ddr dut (
    .TX_DDR_clk (TX_DDR_clk),
    .TX_rst     (TX_rst),
    .bus        (bus)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial begin
    TX_DDR_clk = 1'b0;
    forever #5 TX_DDR_clk = ~TX_DDR_clk;
  end

  // Monitor: compare outputs just after each edge against the scoreboard.
  always @(TX_DDR_clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        n_checks = n_checks + 1;
        if (bus.Dp !== e.dp) begin
          n_fail = n_fail + 1;
          $display("FAIL %s Dp: got %b expected %b (t=%0t)", e.name, bus.Dp, e.dp, $time);
        end
        n_checks = n_checks + 1;
        if (bus.Dn !== ~e.dp) begin
          n_fail = n_fail + 1;
          $display("FAIL %s Dn: got %b expected %b (t=%0t)", e.name, bus.Dn, ~e.dp, $time);
        end
      end
    end
  end

  // Drive one half-period.
  // Inputs settle 2 units after the previous edge.
  // The expectation is for the state right after the coming edge.
  task automatic half(input logic rst, input logic en, input logic b1, input logic b2,
                      input logic chk, input logic exp_dp, input string name);
    exp_t e;
    TX_rst        = rst;
    bus.Enable    = en;
    bus.Serial_B1 = b1;
    bus.Serial_B2 = b2;
    e.chk  = chk;
    e.dp   = exp_dp;
    e.name = name;
    sb_q.push_back(e);
    @(TX_DDR_clk);
    #2;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed edge-by-edge vectors.
  // Comments give the expected (q1,q2) state after each edge.
  initial begin
    TX_rst        = 1'b0;
    bus.Enable    = 1'b0;
    bus.Serial_B1 = 1'b0;
    bus.Serial_B2 = 1'b0;
    @(negedge TX_DDR_clk);
    #2;

    // Reset with Enable low. The first rise clears only q1, so skip that check.
    half(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_rise0");   // (0,X)
    half(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_fall0");   // (0,0)
    half(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_rise1");
    half(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_fall1");

    // DDR launch with B1=1, B2=0: Dp alternates 1,0.
    for (int i = 0; i < 3; i++) begin
      half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "launch_rise");
      half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "launch_fall");
    end                                                      // (1,1)

    // Pattern (1,1),(0,1),(1,0),(0,0): Dp = 1,1,0,1,1,0,0,0.
    half(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "pat11_rise");  // (0,1)
    half(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "pat11_fall");  // (0,1)
    half(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "pat01_rise");  // (1,1)
    half(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "pat01_fall");  // (1,0)
    half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "pat10_rise");  // (1,0)
    half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "pat10_fall");  // (1,1)
    half(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "pat00_rise");  // (1,1)
    half(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "pat00_fall");  // (1,1)

    // Hold: launch a 1, then disable with zeros on the inputs for 3 cycles.
    half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "hold_set");    // (0,1)
    for (int i = 0; i < 6; i++) begin
      half(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "hold");
    end

    // Re-enable with B1=B2=1, starting at a falling edge.
    for (int i = 0; i < 2; i++) begin
      half(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reen_fall"); // (0,1)
      half(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reen_rise"); // (0,1)
    end

    // Enable raised between edges: B2 launches before B1.
    half(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "late_hold_f");
    half(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "late_hold_r");
    half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "late_b2");     // (0,0)
    half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "late_b1");     // (1,0)

    // Mid-stream reset with Enable high.
    // The inputs are chosen so that Enable winning would give a different Dp.
    half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "mid_pre");     // (1,1)
    half(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "mid_rst_r");   // (0,1): q2 lingers
    half(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "mid_rst_f");   // (0,0)
    half(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "mid_rst_r2");
    half(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "mid_rst_f2");

    // Recovery after reset release.
    half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "recover_r");   // (1,0)
    half(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "recover_f");   // (1,1)

    // Every pushed expectation must have been consumed by the monitor.
    n_checks = n_checks + 1;
    if (sb_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_deff_ddr
